// File: rtl/yarvi_io_ctrl_pkg.sv
// Shared constants for the yarvi console controller: register offsets,
// STATUS bit positions and the STATUS word builder.
package yarvi_io_ctrl_pkg;

  localparam logic [1:0] IO_TXDATA = 2'd0;
  localparam logic [1:0] IO_RXDATA = 2'd1;
  localparam logic [1:0] IO_STATUS = 2'd2;
  localparam logic [1:0] IO_IRQEN  = 2'd3;

  localparam int IO_ST_TXFULL  = 1;
  localparam int IO_ST_TXEMPTY = 2;
  localparam int IO_ST_RXVALID = 3;
  localparam int IO_ST_TXOVF   = 4;

  function automatic logic [31:0] status_word(
    input logic ovf,
    input logic rxv,
    input logic emp,
    input logic full
  );
    logic [31:0] w;
    w = '0;
    w[IO_ST_TXOVF]   = ovf;
    w[IO_ST_RXVALID] = rxv;
    w[IO_ST_TXEMPTY] = emp;
    w[IO_ST_TXFULL]  = full;
    return w;
  endfunction

endpackage

// File: rtl/yarvi_io_ctrl_if.sv
// Core-side io bus of the console controller.
// The core is the master, the controller the slave.
interface yarvi_io_ctrl_if;
  logic [29:0] io_address;
  logic [31:0] io_wdata;
  logic [3:0]  io_we;
  logic        io_re;
  logic [31:0] io_rdata;

  modport master (
    output io_address,
    output io_wdata,
    output io_we,
    output io_re,
    input  io_rdata
  );

  modport slave (
    input  io_address,
    input  io_wdata,
    input  io_we,
    input  io_re,
    output io_rdata
  );
endinterface

// File: rtl/yarvi_sync_fifo.sv
// Synchronous FIFO, 2^DEPTH_LOG2 entries; push when full and pop when
// empty are ignored. Head entry is presented combinationally on rdata.
module yarvi_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  do_push;
  logic                  do_pop;

  assign full    = cnt == (DEPTH_LOG2+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/yarvi_io_ctrl.sv
// Memory-mapped console controller: TX FIFO, RX hold byte, STATUS/IRQEN.
// Optional IRQEN register and irq output under YARVI_IO_IRQ_EN.
module yarvi_io_ctrl
  import yarvi_io_ctrl_pkg::*;
#(
  parameter logic [29:0] IO_BASE       = 30'h4000000,
  parameter int          TX_DEPTH_LOG2 = 2
) (
  input  logic            clock,
  input  logic            reset,
  yarvi_io_ctrl_if.slave  bus,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            rx_ready,
  input  logic            tx_ready,
  output logic            tx_valid,
  output logic [7:0]      tx_data,
  output logic            irq
);

  logic [29:0] off;
  logic        in_win;
  logic        sel_tx;
  logic        sel_rx;
  logic        sel_st;
  logic        sel_ie;
  logic        wr;

  assign off    = bus.io_address - IO_BASE;
  assign in_win = off[29:2] == '0;
  assign sel_tx = in_win && off[1:0] == IO_TXDATA;
  assign sel_rx = in_win && off[1:0] == IO_RXDATA;
  assign sel_st = in_win && off[1:0] == IO_STATUS;
  assign sel_ie = in_win && off[1:0] == IO_IRQEN;
  assign wr     = |bus.io_we;

  logic                   tx_wr;
  logic                   tx_pop;
  logic                   tx_full;
  logic                   tx_empty;
  logic [TX_DEPTH_LOG2:0] tx_count;
  logic                   tx_ovf;

  assign tx_wr    = sel_tx && bus.io_we[0];
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;

  yarvi_sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tx_wr),
    .wdata (bus.io_wdata[7:0]),
    .pop   (tx_pop),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  // A push into a full FIFO is lost even if a pop frees a slot this edge
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_ovf <= 1'b0;
    end else if (tx_wr && tx_full) begin
      tx_ovf <= 1'b1;
    end else if (sel_st && wr && bus.io_wdata[IO_ST_TXOVF]) begin
      tx_ovf <= 1'b0;
    end
  end

  logic       hold_valid;
  logic [7:0] hold_data;
  logic       rx_pop;

  assign rx_ready = !hold_valid;
  assign rx_pop   = bus.io_re && sel_rx && hold_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (rx_valid && rx_ready) begin
      hold_valid <= 1'b1;
      hold_data  <= rx_data;
    end else if (rx_pop) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end
  end

  logic [1:0] irqen;

`ifdef YARVI_IO_IRQ_EN
  logic irq_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      irqen <= '0;
      irq_q <= 1'b0;
    end else begin
      if (sel_ie && wr) irqen <= bus.io_wdata[1:0];
      irq_q <= (irqen[0] & hold_valid) | (irqen[1] & tx_empty);
    end
  end

  assign irq = irq_q;
`else
  assign irqen = 2'b00;
  assign irq   = 1'b0;
`endif

  logic [31:0] rd_mux;
  logic [31:0] rdata_q;

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_rx:  rd_mux = {23'b0, hold_valid, hold_data};
      sel_st:  rd_mux = status_word(tx_ovf, hold_valid,
                                    tx_empty, tx_full);
      sel_ie:  rd_mux = {30'b0, irqen};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= bus.io_re ? rd_mux : '0;
    end
  end

  assign bus.io_rdata = rdata_q;

  logic unused_ok;
  assign unused_ok = ^{bus.io_wdata[31:8], tx_count};

endmodule

// File: tb/tb_yarvi_io_ctrl.sv
// Scoreboard bench for yarvi_io_ctrl: TX bytes queued at write time and
// checked on the host handshake; register reads checked directly.
module tb_yarvi_io_ctrl;

  localparam logic [29:0] BASE   = 30'h4000000;
  localparam logic [29:0] OFF_TX = 30'd0;
  localparam logic [29:0] OFF_RX = 30'd1;
  localparam logic [29:0] OFF_ST = 30'd2;
  localparam logic [29:0] OFF_IE = 30'd3;
  localparam logic [29:0] OFF_NA = 30'd4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       irq;

  yarvi_io_ctrl_if bus ();

  yarvi_io_ctrl #(
    .IO_BASE       (BASE),
    .TX_DEPTH_LOG2 (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Host side: the byte on the bus is consumed at the next rising edge
  always @(negedge clock) begin
    if (!reset && tx_valid && tx_ready) begin
      if (sb.size() == 0) chk("tx_unexpected", 32'(sb.size()), 32'd1);
      else chk("tx_byte", {24'b0, tx_data}, {24'b0, sb.pop_front()});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [29:0] o, input logic [31:0] d);
    bus.io_address = BASE + o;
    bus.io_wdata   = d;
    bus.io_we      = 4'hf;
    step();
    bus.io_we      = 4'h0;
  endtask

  task automatic bus_read(input logic [29:0] o, output logic [31:0] d);
    bus.io_address = BASE + o;
    bus.io_re      = 1'b1;
    step();
    bus.io_re      = 1'b0;
    d = bus.io_rdata;
  endtask

  task automatic tx_write(input logic [7:0] b, input bit acc);
    if (acc) sb.push_back(b);
    bus_write(OFF_TX, {24'b0, b});
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  logic [31:0] rd;

  initial begin
    bus.io_address = '0;
    bus.io_wdata   = '0;
    bus.io_we      = '0;
    bus.io_re      = 1'b0;
    rx_valid       = 1'b0;
    rx_data        = '0;
    tx_ready       = 1'b0;
    repeat (3) step();
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
    chk("rst_rdata", bus.io_rdata, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    reset = 1'b0;
    step();
    bus_read(OFF_ST, rd);
    chk("rst_status", rd, 32'h04);

    // 1: three bytes streamed with the host always ready
    tx_ready = 1'b1;
    tx_write(8'h41, 1'b1);
    chk("t1_latency", {31'b0, tx_valid}, 32'd1);
    tx_write(8'h42, 1'b1);
    tx_write(8'h43, 1'b1);
    drain("t1_drain");
    bus_read(OFF_ST, rd);
    chk("t1_status", rd, 32'h04);

    // 2: overflow with the host stalled
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) tx_write(8'h61 + 8'(i), i < 4);
    bus_read(OFF_ST, rd);
    chk("t2_status_ovf", rd, 32'h12);
    tx_ready = 1'b1;
    drain("t2_drain");
    step();
    chk("t2_idle", {31'b0, tx_valid}, 32'd0);
    bus_read(OFF_ST, rd);
    chk("t2_ovf_kept", rd, 32'h14);
    bus_write(OFF_ST, 32'h10);
    bus_read(OFF_ST, rd);
    chk("t2_ovf_clr", rd, 32'h04);

    // 3: host byte held, decode boundaries, then popped
    tx_ready = 1'b0;
    rx_send(8'h5a);
    chk("t3_rx_ready_lo", {31'b0, rx_ready}, 32'd0);
    bus_read(OFF_ST, rd);
    chk("t3_status_rx", rd, 32'h0c);
    bus_read(OFF_NA, rd);
    chk("t3_unmapped_rd", rd, 32'd0);
    bus_read(OFF_TX, rd);
    chk("t3_txdata_rd", rd, 32'd0);
    bus_write(OFF_NA, 32'h99);
    chk("t3_unmapped_wr", {31'b0, tx_valid}, 32'd0);
    bus_read(OFF_RX, rd);
    chk("t3_rxdata", rd, 32'h15a);
    chk("t3_rx_ready_hi", {31'b0, rx_ready}, 32'd1);
    step();
    chk("t3_rdata_idle", bus.io_rdata, 32'd0);
    bus_read(OFF_RX, rd);
    chk("t3_rxdata_empty", rd, 32'd0);

    // 4: push into a full FIFO while the host pops
    for (int i = 0; i < 4; i++) tx_write(8'h71 + 8'(i), 1'b1);
    tx_ready = 1'b1;
    tx_write(8'h75, 1'b0);
    tx_ready = 1'b0;
    bus_read(OFF_ST, rd);
    chk("t4_status", rd, 32'h10);
    tx_ready = 1'b1;
    drain("t4_drain");
    bus_write(OFF_ST, 32'h10);
    step();

    // 5: reset with bytes queued, one held and a read in flight
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) tx_write(8'h81 + 8'(i), 1'b1);
    rx_send(8'h33);
    reset = 1'b1;
    bus.io_address = BASE + OFF_ST;
    bus.io_re = 1'b1;
    step();
    bus.io_re = 1'b0;
    sb.delete();
    chk("t5_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("t5_rx_ready", {31'b0, rx_ready}, 32'd1);
    chk("t5_rdata", bus.io_rdata, 32'd0);
    reset = 1'b0;
    step();
    bus_read(OFF_ST, rd);
    chk("t5_status", rd, 32'h04);
    bus_read(OFF_RX, rd);
    chk("t5_rxdata", rd, 32'd0);

    // 6: interrupt
`ifdef YARVI_IO_IRQ_EN
    bus_write(OFF_IE, 32'h2);
    step();
    chk("t6_irq_txempty", {31'b0, irq}, 32'd1);
    bus_write(OFF_IE, 32'h1);
    step();
    chk("t6_irq_quiet", {31'b0, irq}, 32'd0);
    bus_read(OFF_IE, rd);
    chk("t6_irqen_rd", rd, 32'h1);
    rx_send(8'h77);
    chk("t6_irq_lag", {31'b0, irq}, 32'd0);
    step();
    chk("t6_irq_set", {31'b0, irq}, 32'd1);
    bus_read(OFF_RX, rd);
    chk("t6_rxdata", rd, 32'h177);
    step();
    chk("t6_irq_clr", {31'b0, irq}, 32'd0);
`else
    bus_write(OFF_IE, 32'h3);
    bus_read(OFF_IE, rd);
    chk("t6_irqen_rd", rd, 32'd0);
    rx_send(8'h77);
    step();
    chk("t6_irq_off", {31'b0, irq}, 32'd0);
    bus_read(OFF_RX, rd);
    chk("t6_rxdata", rd, 32'h177);
    step();
    chk("t6_irq_off2", {31'b0, irq}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
